// File: rtl/ariane_pkg.sv
// ============================================================================
// Module      : ariane_pkg
// Description : Shared definitions for the hardware performance monitor.
//               Holds the register-space selector encoding, the event-select
//               field width and the event index constants that identify
//               which bit slice of event_inc_i each event source drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

    // Register space selected by sel_i on the CSR-side port
    typedef enum logic [1:0] {
        HPM_CNT   = 2'd0,   // counter value, indexed by addr_i
        HPM_EVSEL = 2'd1,   // event select, indexed by addr_i
        HPM_INH   = 2'd2,   // inhibit mask, one bit per counter
        HPM_OVF   = 2'd3    // sticky overflow status, write-1-to-clear
    } hpm_sel_e;

    localparam int HPM_EVSEL_W = 5;

    // Event source positions within event_inc_i. An event select value of
    // (index + 1) binds a counter to that source; 0 means "no event".
    localparam int ICACHE_MISS = 0;
    localparam int DCACHE_MISS = 1;
    localparam int ITLB_MISS   = 2;
    localparam int DTLB_MISS   = 3;
    localparam int LOAD        = 4;
    localparam int STORE       = 5;
    localparam int BRANCH      = 6;
    localparam int CALL        = 7;
    localparam int RET         = 8;
    localparam int EXCEPTION   = 9;
    localparam int ERET        = 10;
    localparam int MISPREDICT  = 11;
    localparam int SB_FULL     = 12;
    localparam int IF_EMPTY    = 13;

endpackage

`default_nettype wire

// File: rtl/hpm_counter.sv
// ============================================================================
// Module      : hpm_counter
// Description : One performance counter: value register, increment adder,
//               carry-out detection and write-over-increment priority.
// Ports       : clk_i, rst_ni   - clock, asynchronous active-low reset
//               i_inc           - increment for this cycle (already gated)
//               i_we            - load i_wdata instead of counting
//               i_wdata         - load value
//               o_cnt           - current counter value (q)
//               o_ovf_set       - this cycle's increment wraps the counter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_counter #(
    parameter int CNT_WIDTH = 48,
    parameter int INC_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [INC_WIDTH-1:0] i_inc,
    input  logic                 i_we,
    input  logic [CNT_WIDTH-1:0] i_wdata,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_ovf_set
);

    // The sum is wide enough for either operand plus a carry, so narrow
    // counters fed by wide increments still report their overflow.
    localparam int SUM_W = ((CNT_WIDTH > INC_WIDTH) ? CNT_WIDTH : INC_WIDTH) + 1;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_carry;

    assign w_sum   = SUM_W'(r_cnt) + SUM_W'(i_inc);
    assign w_carry = |w_sum[SUM_W-1:CNT_WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_we) begin
            r_cnt <= i_wdata;
        end else begin
            r_cnt <= w_sum[CNT_WIDTH-1:0];
        end
    end

    // A software load drops the increment, so it can never flag an overflow.
    assign o_ovf_set = w_carry & ~i_we;
    assign o_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hpm_counters.sv
// ============================================================================
// Module      : hpm_counters
// Description : Hardware performance monitor. NUM_COUNTERS counters, each
//               bound at run time to one of NUM_EVENTS multi-increment event
//               sources, with per-counter inhibit, sticky overflow status and
//               an optional registered overflow interrupt.
// Ports       : clk_i, rst_ni   - clock, asynchronous active-low reset
//               debug_mode_i    - freezes all counting while high
//               sel_i, addr_i   - register space and counter index
//               we_i, data_i    - write enable and write data
//               data_o          - combinational read data (pre-write value)
//               event_inc_i     - packed per-event increments
//               irq_o           - OR of overflow status (HPM_OVF_IRQ_EN only)
// Config      : define HPM_OVF_IRQ_EN to add the irq_o port and its register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpm_counters
    import ariane_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int CNT_WIDTH    = 48,
    parameter int NUM_EVENTS   = 16,
    parameter int INC_WIDTH    = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             debug_mode_i,
    input  logic [1:0]                       sel_i,
    input  logic [4:0]                       addr_i,
    input  logic                             we_i,
    input  logic [63:0]                      data_i,
    output logic [63:0]                      data_o,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0]  event_inc_i
`ifdef HPM_OVF_IRQ_EN
    ,
    output logic                             irq_o
`endif
);

    hpm_sel_e                  w_sel;
    logic [CNT_WIDTH-1:0]      w_cnt [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]   w_ovf_set;
    logic [NUM_COUNTERS-1:0]   w_ovf_clr;
    logic [NUM_COUNTERS-1:0]   w_ovf_d;
    logic [HPM_EVSEL_W-1:0]    r_evsel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]   r_inh;
    logic [NUM_COUNTERS-1:0]   r_ovf;
    logic                      w_unused_data;

    assign w_sel         = hpm_sel_e'(sel_i);
    assign w_unused_data = &{1'b0, data_i};

    // ------------------------------------------------------------------
    // Per-counter event select mux and counter instance
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_cnt
        logic [INC_WIDTH-1:0] w_inc;
        logic                 w_cnt_we;

        // Selects outside 1..NUM_EVENTS match no source and count nothing.
        always_comb begin
            w_inc = '0;
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if (r_evsel[n] == HPM_EVSEL_W'(k)) begin
                    w_inc = event_inc_i[(k-1)*INC_WIDTH +: INC_WIDTH];
                end
            end
            // Inhibit uses the registered mask, so a same-cycle inhibit
            // write only takes effect from the following cycle.
            if (r_inh[n] || debug_mode_i) begin
                w_inc = '0;
            end
        end

        assign w_cnt_we = we_i && (w_sel == HPM_CNT) && (addr_i == 5'(n));

        hpm_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (INC_WIDTH)
        ) u_hpm_counter (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .i_inc     (w_inc),
            .i_we      (w_cnt_we),
            .i_wdata   (data_i[CNT_WIDTH-1:0]),
            .o_cnt     (w_cnt[n]),
            .o_ovf_set (w_ovf_set[n])
        );
    end

    // ------------------------------------------------------------------
    // Event select, inhibit and overflow registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                r_evsel[n] <= '0;
            end
        end else if (we_i && (w_sel == HPM_EVSEL)) begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                if (addr_i == 5'(n)) begin
                    r_evsel[n] <= data_i[HPM_EVSEL_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inh <= '0;
        end else if (we_i && (w_sel == HPM_INH)) begin
            r_inh <= data_i[NUM_COUNTERS-1:0];
        end
    end

    // Clear is applied first so a same-cycle overflow wins over W1C.
    assign w_ovf_clr = (we_i && (w_sel == HPM_OVF)) ? data_i[NUM_COUNTERS-1:0] : '0;
    assign w_ovf_d   = (r_ovf & ~w_ovf_clr) | w_ovf_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= w_ovf_d;
        end
    end

`ifdef HPM_OVF_IRQ_EN
    // Registered from the next-state status so irq_o tracks ovf exactly.
    logic r_irq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_ovf_d;
        end
    end

    assign irq_o = r_irq;
`endif

    // ------------------------------------------------------------------
    // Read mux: always the pre-write register contents
    // ------------------------------------------------------------------
    always_comb begin
        data_o = '0;
        case (w_sel)
            HPM_CNT: begin
                for (int n = 0; n < NUM_COUNTERS; n++) begin
                    if (addr_i == 5'(n)) begin
                        data_o = 64'(w_cnt[n]);
                    end
                end
            end
            HPM_EVSEL: begin
                for (int n = 0; n < NUM_COUNTERS; n++) begin
                    if (addr_i == 5'(n)) begin
                        data_o = 64'(r_evsel[n]);
                    end
                end
            end
            HPM_INH: data_o = 64'(r_inh);
            HPM_OVF: data_o = 64'(r_ovf);
            default: data_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hpm_counters.sv
// ============================================================================
// Module      : tb_hpm_counters
// Description : Self-checking bench for hpm_counters. The driver issues
//               directed reads/writes and pushes hand-computed expected read
//               data into a queue; a monitor pops and compares on every
//               strobed read at the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpm_counters;
    import ariane_pkg::*;

    localparam int NC  = 8;
    localparam int CW  = 48;
    localparam int NE  = 16;
    localparam int IW  = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              debug_mode_i = 1'b0;
    logic [1:0]        sel_i = 2'd0;
    logic [4:0]        addr_i = 5'd0;
    logic              we_i = 1'b0;
    logic [63:0]       data_i = 64'd0;
    logic [63:0]       data_o;
    logic [NE*IW-1:0]  event_inc_i = '0;
`ifdef HPM_OVF_IRQ_EN
    logic              irq_o;
`endif

    hpm_counters #(
        .NUM_COUNTERS (NC),
        .CNT_WIDTH    (CW),
        .NUM_EVENTS   (NE),
        .INC_WIDTH    (IW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .debug_mode_i (debug_mode_i),
        .sel_i        (sel_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .event_inc_i  (event_inc_i)
`ifdef HPM_OVF_IRQ_EN
        ,
        .irq_o        (irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t q_exp[$];
    logic chk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: one comparison per strobed read
    always @(negedge clk_i) begin
        if (chk) begin
            n_checks++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL %s: read with empty scoreboard, got 0x%0h", "sb_empty", data_o);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                if (data_o !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, data_o, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [4:0] a, input logic [63:0] d);
        sel_i  = s;
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        tick();
        we_i   = 1'b0;
        data_i = 64'd0;
    endtask

    task automatic rd(input logic [1:0] s, input logic [4:0] a, input logic [63:0] v, input string nm);
        sel_i  = s;
        addr_i = a;
        q_exp.push_back('{name: nm, val: v});
        chk = 1'b1;
        tick();
        chk = 1'b0;
    endtask

    task automatic set_ev(input int k, input logic [IW-1:0] v);
        event_inc_i[k*IW +: IW] = v;
    endtask

`ifdef HPM_OVF_IRQ_EN
    task automatic chk_irq(input logic exp_v, input string nm);
        n_checks++;
        if (irq_o !== exp_v) begin
            n_fail++;
            $display("FAIL %s: irq_o got %0b expected %0b", nm, irq_o, exp_v);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_ni = 1'b0;
        tick();
        tick();
        rd(2'd0, 5'd0, 64'd0, "reset_cnt0");
        rst_ni = 1'b1;
        tick();
        rd(2'd1, 5'd0, 64'd0, "reset_evsel0");
        rd(2'd2, 5'd0, 64'd0, "reset_inh");
        rd(2'd3, 5'd0, 64'd0, "reset_ovf");
`ifdef HPM_OVF_IRQ_EN
        chk_irq(1'b0, "reset_irq");
`endif

        // cnt[0] counts event 0 for 10 cycles
        wr(2'd1, 5'd0, 64'd1);
        set_ev(0, 2'd1);
        for (int i = 0; i < 10; i++) tick();
        set_ev(0, 2'd0);
        rd(2'd0, 5'd0, 64'd10, "cnt0_ten");
        for (int i = 1; i < NC; i++) rd(2'd0, 5'(i), 64'd0, "cnt_other_zero");

        // debug_mode freezes two of five cycles: 3 * 2 = 6
        wr(2'd1, 5'd2, 64'd3);
        set_ev(2, 2'd2);
        for (int i = 0; i < 5; i++) begin
            debug_mode_i = (i == 1 || i == 2);
            tick();
        end
        debug_mode_i = 1'b0;
        set_ev(2, 2'd0);
        rd(2'd0, 5'd2, 64'd6, "cnt2_debug");
        rd(2'd1, 5'd2, 64'd3, "evsel2");

        // Overflow: (2^48-2)+3 -> 1, ovf bit 1; cnt[0] also gains 3 -> 13
        wr(2'd0, 5'd1, 64'h0000_FFFF_FFFF_FFFE);
        wr(2'd1, 5'd1, 64'd1);
        set_ev(0, 2'd3);
        tick();
        set_ev(0, 2'd0);
`ifdef HPM_OVF_IRQ_EN
        chk_irq(1'b1, "irq_set");
`endif
        rd(2'd0, 5'd1, 64'd1, "cnt1_wrap3");
        rd(2'd3, 5'd0, 64'h2, "ovf_bit1");
        rd(2'd0, 5'd0, 64'd13, "cnt0_plus3");
        wr(2'd3, 5'd0, 64'h2);
`ifdef HPM_OVF_IRQ_EN
        chk_irq(1'b0, "irq_clear");
`endif
        rd(2'd3, 5'd0, 64'h0, "ovf_w1c");

        // All-ones + 1 wraps to 0 while a W1C of the same bit is written
        wr(2'd0, 5'd3, 64'h0000_FFFF_FFFF_FFFF);
        wr(2'd1, 5'd3, 64'd2);
        set_ev(1, 2'd1);
        wr(2'd3, 5'd0, 64'h8);
        set_ev(1, 2'd0);
        rd(2'd0, 5'd3, 64'd0, "cnt3_wrap1");
        rd(2'd3, 5'd0, 64'h8, "ovf_set_wins");
        wr(2'd3, 5'd0, 64'h8);
        rd(2'd3, 5'd0, 64'h0, "ovf_cleared");

        // Write beats a same-cycle increment; the read sees the old value
        set_ev(0, 2'd1);
        sel_i  = 2'd0;
        addr_i = 5'd0;
        data_i = 64'h55;
        we_i   = 1'b1;
        q_exp.push_back('{name: "cnt0_old_on_write", val: 64'd13});
        chk = 1'b1;
        tick();
        chk  = 1'b0;
        we_i = 1'b0;
        set_ev(0, 2'd0);
        rd(2'd0, 5'd0, 64'h55, "cnt0_write_wins");
        rd(2'd0, 5'd1, 64'd2, "cnt1_same_cycle_inc");
        rd(2'd3, 5'd0, 64'h0, "ovf_no_set_by_write");

        // Inhibit counter 0 for four cycles; counter 1 keeps counting
        wr(2'd2, 5'd0, 64'h1);
        rd(2'd2, 5'd0, 64'h1, "inh_mask");
        set_ev(0, 2'd1);
        for (int i = 0; i < 4; i++) tick();
        // Inhibit change is written while the event is still active: this
        // cycle still uses the old mask (cnt0 frozen, cnt1 counts)
        wr(2'd2, 5'd0, 64'h2);
        tick();
        set_ev(0, 2'd0);
        rd(2'd0, 5'd0, 64'h56, "cnt0_inhibit");
        rd(2'd0, 5'd1, 64'd7, "cnt1_inhibit");

        // Out-of-range index
        rd(2'd0, 5'd20, 64'd0, "cnt_oob_read");
        rd(2'd1, 5'd20, 64'd0, "evsel_oob_read");
        wr(2'd0, 5'd20, 64'hFFFF);
        wr(2'd1, 5'd20, 64'h1F);
        rd(2'd0, 5'd20, 64'd0, "cnt_oob_after_write");
        rd(2'd0, 5'd4, 64'd0, "cnt4_untouched");
        rd(2'd0, 5'd0, 64'h56, "cnt0_untouched");
        rd(2'd1, 5'd4, 64'd0, "evsel4_untouched");

        // Asynchronous reset mid-operation
        rst_ni = 1'b0;
        #1;
        rd(2'd0, 5'd1, 64'd0, "async_reset_cnt1");
        rst_ni = 1'b1;
        rd(2'd1, 5'd1, 64'd0, "post_reset_evsel1");
        rd(2'd2, 5'd0, 64'd0, "post_reset_inh");

        tick();
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
